keypad_preset_writer: RTL and testbench
=======================================

// Module: keypad_preset_writer
// PURPOSE
// - Scans a 4x4 matrix keypad, debounces presses, and issues one-cycle write strobes on the preset-time
//   interface (cs / w_r / addr / data) that loads red (addr 0) and yellow (addr 1) durations into the
//   preset-time register block.
// - Sits beside the preset-time register block in the traffic-light top, replacing the single push-button entry.
// PARAMETERS
// - SCAN_DIV    50000  clk cycles per column step (1 ms at 50 MHz); rows sampled on the last cycle of each step
// - DEBOUNCE_N  20     consecutive identical samples needed to accept a press or a release
// - DATA_W      6      width of the written time value; max value 2**DATA_W-1
// PORTS
// - clk           in   1       system clock (50 MHz)
// - reset         in   1       asynchronous, active-high reset
// - row_in        in   4       keypad rows, active-low, externally pulled up
// - col_out       out  4       column drive, one column low at a time
// - key_valid     out  1       one-cycle pulse per accepted press
// - key_code      out  4       code of last accepted key
// - entry_bcd     out  8       {tens, ones} BCD digits being entered, for the display
// - entry_addr    out  1       selected target register (0 = red, 1 = yellow)
// - wr_cs         out  1       write select, high only during a write cycle
// - wr_en         out  1       w_r strobe, one cycle per write
// - wr_addr       out  1       write address, valid while wr_en = 1
// - wr_data       out  DATA_W  write value, valid while wr_en = 1
// - err           out  1       one-cycle pulse when a commit is rejected
// BEHAVIOUR
// - Reset values: col_out = 4'b1110; all other outputs 0.
// - Reset is asynchronous: asserting it mid-scan or mid-write returns every output and state to reset values at once.
// - Key map: key_code = row*4 + col maps to keys 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D.
//   Codes: digits 0-9 = value, A = 10, B = 11, C = 12, D = 13, * = 14, # = 15.
// - Scan FSM:
//   - SCAN: rotate the low column 0->1->2->3->0 every SCAN_DIV cycles. A sample with any row low latches
//     (row, col) -> DEBOUNCE; the lowest-index low row wins.
//   - DEBOUNCE: freeze the column and sample every SCAN_DIV. After DEBOUNCE_N samples of the same row,
//     key_valid pulses for one cycle, key_code updates, -> RELEASE. A differing sample -> SCAN, with no output.
//   - RELEASE: column stays frozen. DEBOUNCE_N consecutive all-high samples -> SCAN at the next column.
//     Exactly one key_valid per press; no auto-repeat.
// - Entry FSM, one cycle after key_valid:
//   - digit key: tens <= ones, ones <= digit.
//   - A: entry_addr <= 0. B: entry_addr <= 1.
//   - C: entry_bcd <= 0.
//   - *, #: ignored.
//   - D: compute v = tens*10 + ones. If v == 0, pulse err and skip the write. Otherwise set v = min(v, 2**DATA_W-1)
//     and drive wr_cs = wr_en = 1 for exactly one cycle with wr_addr = entry_addr and wr_data = v.
//     entry_bcd clears on the same cycle. wr_data holds its value afterwards; wr_cs and wr_en return to 0.
// - Latency: D accepted (key_valid) -> wr_en high on the next cycle.
// - Simultaneous events: only one key is processed per press, so a write and a new key_valid never overlap.
// STRUCTURE
// - Shared package: key-code constants (KEY_A..KEY_HASH), address constants ADDR_RED = 0 and ADDR_YELLOW = 1.
// - Sub-module keypad_matrix_scan: column rotation, divider, debounce, release wait; outputs key_valid/key_code.
// - Top level: entry FSM, BCD-to-binary conversion, saturation, write strobe.
// TESTING (SCAN_DIV = 4, DEBOUNCE_N = 3)
// - Press row 2 col 1 (key 8), held stable -> exactly one key_valid, key_code = 9;
//   held 50 samples -> no second pulse.
// - Bounce: row low for 2 samples, high, then low for 3 -> single key_valid, issued only after the stable run.
// - Keys B, 2, 5, D -> wr_cs = wr_en = 1 for 1 cycle, wr_addr = 1, wr_data = 25; entry_bcd = 0 afterwards.
// - Keys 9, 9, D -> wr_data = 63 (saturated), wr_addr = 0. Keys C, D -> err pulse, no wr_en.
// - Two keys in the same column (rows 1 and 3) -> key_code reflects row 1.
// - Assert reset during DEBOUNCE and during the wr_en cycle -> outputs immediately at reset values,
//   col_out = 4'b1110, no write completes.

Source files
------------

// File: rtl/keypad_preset_writer_pkg.sv
// Shared definitions for the keypad preset writer.
//   - Logical key values (digits are 0-9; letters and symbols follow).
//   - Preset-time register addresses.
//   - Scan FSM state type.
//   - key_value(): translates a physical key position (row*4 + col) into its logical key value.
package keypad_preset_writer_pkg;

    localparam logic [3:0] KEY_A    = 4'd10;
    localparam logic [3:0] KEY_B    = 4'd11;
    localparam logic [3:0] KEY_C    = 4'd12;
    localparam logic [3:0] KEY_D    = 4'd13;
    localparam logic [3:0] KEY_STAR = 4'd14;
    localparam logic [3:0] KEY_HASH = 4'd15;

    localparam logic ADDR_RED    = 1'b0;
    localparam logic ADDR_YELLOW = 1'b1;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_RELEASE  = 2'd2
    } scan_state_e;

    // Keypad layout, by row: 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D
    function automatic logic [3:0] key_value(input logic [3:0] pos);
        logic [3:0] v;
        case (pos)
            4'd0:    v = 4'd1;
            4'd1:    v = 4'd2;
            4'd2:    v = 4'd3;
            4'd3:    v = KEY_A;
            4'd4:    v = 4'd4;
            4'd5:    v = 4'd5;
            4'd6:    v = 4'd6;
            4'd7:    v = KEY_B;
            4'd8:    v = 4'd7;
            4'd9:    v = 4'd8;
            4'd10:   v = 4'd9;
            4'd11:   v = KEY_C;
            4'd12:   v = KEY_STAR;
            4'd13:   v = 4'd0;
            4'd14:   v = KEY_HASH;
            default: v = KEY_D;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/keypad_preset_writer_matrix_scan.sv
// Matrix keypad scanner with debounce and release wait.
// Ports:
//   clk, reset   system clock, asynchronous active-high reset
//   row_in[3:0]  keypad rows, active-low
//   col_out[3:0] column drive, exactly one column low
//   key_valid    one-cycle pulse per accepted press
//   key_code     physical position of the last accepted key (row*4 + col)
// Rows are sampled on the last cycle of each SCAN_DIV-cycle step. The detecting
// sample counts as the first of the DEBOUNCE_N matching samples (DEBOUNCE_N >= 2).
module keypad_matrix_scan
    import keypad_preset_writer_pkg::*;
#(
    parameter int SCAN_DIV   = 50000,
    parameter int DEBOUNCE_N = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic       key_valid,
    output logic [3:0] key_code
);

    localparam int DIV_W = $clog2(SCAN_DIV + 1);
    localparam int CNT_W = $clog2(DEBOUNCE_N + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_N - 1);

    scan_state_e      state_q;
    logic [DIV_W-1:0] div_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       col_q;
    logic [1:0]       row_q;
    logic [3:0]       col_out_q;
    logic             key_valid_q;
    logic [3:0]       key_code_q;

    logic       sample;
    logic       any_low;
    logic [1:0] low_row;

    // Lowest-index low row wins when several rows are pressed in one column.
    always_comb begin
        sample  = (div_q == DIV_LAST);
        any_low = ~&row_in;
        low_row = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!row_in[i]) low_row = 2'(i);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_SCAN;
            div_q       <= '0;
            cnt_q       <= '0;
            col_q       <= 2'd0;
            row_q       <= 2'd0;
            col_out_q   <= 4'b1110;
            key_valid_q <= 1'b0;
            key_code_q  <= 4'd0;
        end else begin
            key_valid_q <= 1'b0;
            div_q       <= sample ? '0 : div_q + 1'b1;
            if (sample) begin
                case (state_q)
                    ST_SCAN: begin
                        if (any_low) begin
                            row_q   <= low_row;
                            cnt_q   <= CNT_W'(1);
                            state_q <= ST_DEBOUNCE;
                        end else begin
                            col_q     <= col_q + 2'd1;
                            col_out_q <= {col_out_q[2:0], col_out_q[3]};
                        end
                    end
                    ST_DEBOUNCE: begin
                        if (any_low && (low_row == row_q)) begin
                            if (cnt_q == CNT_LAST) begin
                                key_valid_q <= 1'b1;
                                key_code_q  <= {row_q, col_q};
                                cnt_q       <= '0;
                                state_q     <= ST_RELEASE;
                            end else begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                        end else begin
                            // Bounce: drop the candidate silently and resume scanning.
                            state_q   <= ST_SCAN;
                            col_q     <= col_q + 2'd1;
                            col_out_q <= {col_out_q[2:0], col_out_q[3]};
                        end
                    end
                    ST_RELEASE: begin
                        if (!any_low) begin
                            if (cnt_q == CNT_LAST) begin
                                cnt_q     <= '0;
                                state_q   <= ST_SCAN;
                                col_q     <= col_q + 2'd1;
                                col_out_q <= {col_out_q[2:0], col_out_q[3]};
                            end else begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                        end else begin
                            cnt_q <= '0;
                        end
                    end
                    default: state_q <= ST_SCAN;
                endcase
            end
        end
    end

    assign col_out   = col_out_q;
    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;

endmodule

// File: rtl/keypad_preset_writer.sv
// Keypad entry of red/yellow preset durations with one-cycle write strobes.
// Ports:
//   clk, reset       system clock, asynchronous active-high reset
//   row_in[3:0]      keypad rows (active-low);  col_out[3:0] column drive
//   key_valid        one-cycle pulse per accepted key; key_code = row*4 + col
//   entry_bcd[7:0]   {tens, ones} being entered;  entry_addr  0 = red, 1 = yellow
//   wr_cs, wr_en     high together for one cycle per write
//   wr_addr, wr_data write address/value (wr_data holds after the strobe)
//   err              one-cycle pulse when a zero value is committed
// Keys: digits shift in, A/B select red/yellow, C clears, D commits, * and # ignored.
module keypad_preset_writer
    import keypad_preset_writer_pkg::*;
#(
    parameter int SCAN_DIV   = 50000,
    parameter int DEBOUNCE_N = 20,
    parameter int DATA_W     = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        row_in,
    output logic [3:0]        col_out,
    output logic              key_valid,
    output logic [3:0]        key_code,
    output logic [7:0]        entry_bcd,
    output logic              entry_addr,
    output logic              wr_cs,
    output logic              wr_en,
    output logic              wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              err
);

    localparam int unsigned MAX_V = (2 ** DATA_W) - 1;

    logic       kv;
    logic [3:0] kc;

    keypad_matrix_scan #(
        .SCAN_DIV   (SCAN_DIV),
        .DEBOUNCE_N (DEBOUNCE_N)
    ) u_scan (
        .clk       (clk),
        .reset     (reset),
        .row_in    (row_in),
        .col_out   (col_out),
        .key_valid (kv),
        .key_code  (kc)
    );

    logic [3:0]        tens_q, ones_q;
    logic              addr_q;
    logic              wr_en_q;
    logic              wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;
    logic              err_q;

    logic [3:0]        key_val_d;
    logic [6:0]        bin_d;
    logic [DATA_W-1:0] sat_d;

    always_comb begin
        key_val_d = key_value(kc);
        bin_d     = 7'(tens_q) * 7'd10 + 7'(ones_q);
        sat_d     = (32'(bin_d) > MAX_V) ? DATA_W'(MAX_V) : DATA_W'(bin_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tens_q    <= 4'd0;
            ones_q    <= 4'd0;
            addr_q    <= ADDR_RED;
            wr_en_q   <= 1'b0;
            wr_addr_q <= 1'b0;
            wr_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            err_q   <= 1'b0;
            if (kv) begin
                if (key_val_d <= 4'd9) begin
                    tens_q <= ones_q;
                    ones_q <= key_val_d;
                end else begin
                    case (key_val_d)
                        KEY_A: addr_q <= ADDR_RED;
                        KEY_B: addr_q <= ADDR_YELLOW;
                        KEY_C: begin
                            tens_q <= 4'd0;
                            ones_q <= 4'd0;
                        end
                        KEY_D: begin
                            if (bin_d == 7'd0) begin
                                err_q <= 1'b1;
                            end else begin
                                wr_en_q   <= 1'b1;
                                wr_addr_q <= addr_q;
                                wr_data_q <= sat_d;
                            end
                            tens_q <= 4'd0;
                            ones_q <= 4'd0;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign key_valid  = kv;
    assign key_code   = kc;
    assign entry_bcd  = {tens_q, ones_q};
    assign entry_addr = addr_q;
    assign wr_cs      = wr_en_q;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign err        = err_q;

endmodule

// File: tb/tb_keypad_preset_writer.sv
// Bench for keypad_preset_writer with SCAN_DIV = 4, DEBOUNCE_N = 3.
// A keypad model pulls a row low whenever a pressed key's column is driven low.
module tb_keypad_preset_writer;

  localparam logic [3:0] KA = 4'd10, KB = 4'd11, KC = 4'd12, KD = 4'd13, KS = 4'd14, KH = 4'd15;
  // Logical key value at each physical position row*4 + col.
  localparam int LAYOUT [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic       key_valid;
  logic [3:0] key_code;
  logic [7:0] entry_bcd;
  logic       entry_addr;
  logic       wr_cs, wr_en, wr_addr, err;
  logic [5:0] wr_data;

  logic [15:0] pressed = '0;

  keypad_preset_writer #(.SCAN_DIV(4), .DEBOUNCE_N(3), .DATA_W(6)) dut (
    .clk(clk), .reset(reset), .row_in(row_in), .col_out(col_out),
    .key_valid(key_valid), .key_code(key_code), .entry_bcd(entry_bcd),
    .entry_addr(entry_addr), .wr_cs(wr_cs), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .err(err)
  );

  // clock / reset
  always #5 clk = ~clk;

  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!col_out[c] && pressed[r*4+c]) row_in[r] = 1'b0;
  end

  int checks = 0;
  int errors = 0;
  int kv_count = 0, wr_count = 0, err_count = 0;
  logic [3:0] last_code = '0;
  logic       last_waddr = 1'b0;
  logic [5:0] last_wdata = '0;
  logic       prev_kv = 1'b0, prev_wr = 1'b0;
  logic [3:0] prev_code = '0;

  // scoreboard
  bit         chk_en = 1'b0;
  logic [6:0] exp_q[$];
  logic [6:0] exp_e;
  int         exp_err = 0;
  logic [3:0] m_tens, m_ones;
  logic       m_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Output monitor: counts events and checks every write strobe.
  always @(negedge clk) begin
    if (key_valid) begin
      kv_count++;
      last_code = key_code;
    end
    if (err) err_count++;
    if (wr_en) begin
      wr_count++;
      check("wr_cs_with_wr_en", wr_cs, 1);
      check("wr_one_cycle_after_D", {prev_kv, prev_code}, {1'b1, 4'd15});
      check("wr_single_cycle", prev_wr, 0);
      last_waddr = wr_addr;
      last_wdata = wr_data;
      if (chk_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %0d data %0d, expected no write", wr_addr, wr_data);
        end else begin
          exp_e = exp_q.pop_front();
          check("rand_write_addr_data", {wr_addr, wr_data}, exp_e);
        end
      end
    end
    prev_kv   = key_valid;
    prev_code = key_code;
    prev_wr   = wr_en;
  end

  // driver tasks
  function automatic int pos_of(input logic [3:0] v);
    for (int p = 0; p < 16; p++)
      if (LAYOUT[p] == int'(v)) return p;
    return 0;
  endfunction

  task automatic press(input int pos, input int hold);
    pressed = '0;
    pressed[pos] = 1'b1;
    repeat (hold) @(negedge clk);
    pressed = '0;
    repeat (40) @(negedge clk);
  endtask

  task automatic do_reset();
    pressed = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_col_out"}, col_out, 4'b1110);
    check({tag, "_other_outputs"},
          {key_valid, key_code, entry_bcd, entry_addr, wr_cs, wr_en, wr_addr, wr_data, err}, 0);
  endtask

  // Reference entry model: shift digits, select, clear, commit with saturation.
  task automatic model_key(input logic [3:0] v);
    int val;
    if (v <= 4'd9) begin
      m_tens = m_ones;
      m_ones = v;
    end else if (v == KA) m_addr = 1'b0;
    else if (v == KB) m_addr = 1'b1;
    else if (v == KC) begin
      m_tens = 4'd0;
      m_ones = 4'd0;
    end else if (v == KD) begin
      val = int'(m_tens) * 10 + int'(m_ones);
      if (val == 0) exp_err++;
      else begin
        if (val > 63) val = 63;
        exp_q.push_back({m_addr, 6'(val)});
      end
      m_tens = 4'd0;
      m_ones = 4'd0;
    end
  endtask

  typedef struct {
    int              nk;
    logic [3:0][3:0] k;
    bit              exp_wr;
    bit              exp_err;
    bit              exp_waddr;
    int              exp_data;
    logic [7:0]      exp_bcd;
    bit              exp_eaddr;
  } vec_t;

  function automatic vec_t mk(input int nk, input logic [3:0] k0, input logic [3:0] k1,
                              input logic [3:0] k2, input logic [3:0] k3, input bit w,
                              input bit e, input bit wa, input int d, input logic [7:0] bcd,
                              input bit ea);
    vec_t t;
    t.nk = nk;
    t.k[0] = k0; t.k[1] = k1; t.k[2] = k2; t.k[3] = k3;
    t.exp_wr = w; t.exp_err = e; t.exp_waddr = wa; t.exp_data = d;
    t.exp_bcd = bcd; t.exp_eaddr = ea;
    return t;
  endfunction

  vec_t tbl[10];
  int   base, base_wr, base_err;
  int   r, v;

  initial begin
    tbl[0] = mk(4, KB, 4'd2, 4'd5, KD, 1, 0, 1, 25, 8'h00, 1);
    tbl[1] = mk(4, KA, 4'd9, 4'd9, KD, 1, 0, 0, 63, 8'h00, 0);
    tbl[2] = mk(2, KC, KD, 4'd0, 4'd0, 0, 1, 0, 0, 8'h00, 0);
    tbl[3] = mk(4, KB, 4'd0, 4'd7, KD, 1, 0, 1, 7, 8'h00, 1);
    tbl[4] = mk(4, KA, 4'd6, 4'd4, KD, 1, 0, 0, 63, 8'h00, 0);
    tbl[5] = mk(3, 4'd6, 4'd3, KD, 4'd0, 1, 0, 0, 63, 8'h00, 0);
    tbl[6] = mk(3, 4'd5, KS, KH, 4'd0, 0, 0, 0, 0, 8'h05, 0);
    tbl[7] = mk(4, 4'd1, 4'd2, 4'd3, KC, 0, 0, 0, 0, 8'h00, 0);
    tbl[8] = mk(3, 4'd4, 4'd2, KD, 4'd0, 1, 0, 0, 42, 8'h00, 0);
    tbl[9] = mk(3, KB, 4'd1, KD, 4'd0, 1, 0, 1, 1, 8'h00, 1);

    // reset state
    repeat (2) @(negedge clk);
    check_reset("por");
    reset = 1'b0;

    // Key 8 (row 2, col 1) held for more than 50 samples: one pulse, code 9.
    base = kv_count;
    press(9, 230);
    #1;
    check("hold_single_pulse", kv_count - base, 1);
    check("hold_key_code", last_code, 9);
    check("hold_entry_digit", entry_bcd, 8'h08);

    // Bounce on key 1 (col 0): two samples low, one high, then a stable press.
    do_reset();
    base = kv_count;
    pressed[0] = 1'b1;
    repeat (8) @(negedge clk);
    pressed[0] = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check("bounce_no_early_pulse", kv_count - base, 0);
    press(0, 60);
    #1;
    check("bounce_single_pulse", kv_count - base, 1);
    check("bounce_key_code", last_code, 0);

    // Rows 1 and 3 pressed in column 2: row 1 wins.
    base = kv_count;
    pressed = '0;
    pressed[6] = 1'b1;
    pressed[14] = 1'b1;
    repeat (60) @(negedge clk);
    pressed = '0;
    repeat (40) @(negedge clk);
    #1;
    check("two_rows_single_pulse", kv_count - base, 1);
    check("two_rows_key_code", last_code, 6);

    // Table-driven commit sequences.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      base_wr  = wr_count;
      base_err = err_count;
      for (int j = 0; j < tbl[i].nk; j++) press(pos_of(tbl[i].k[j]), 60);
      #1;
      check($sformatf("vec%0d_writes", i), wr_count - base_wr, tbl[i].exp_wr);
      check($sformatf("vec%0d_errs", i), err_count - base_err, tbl[i].exp_err);
      if (tbl[i].exp_wr) begin
        check($sformatf("vec%0d_wr_addr", i), last_waddr, tbl[i].exp_waddr);
        check($sformatf("vec%0d_wr_data", i), last_wdata, tbl[i].exp_data);
        check($sformatf("vec%0d_wr_data_held", i), wr_data, tbl[i].exp_data);
      end
      check($sformatf("vec%0d_entry_bcd", i), entry_bcd, tbl[i].exp_bcd);
      check($sformatf("vec%0d_entry_addr", i), entry_addr, tbl[i].exp_eaddr);
      check($sformatf("vec%0d_strobe_idle", i), {wr_cs, wr_en}, 0);
    end

    // Reset while debouncing key 8 in column 1.
    do_reset();
    base = kv_count;
    pressed[9] = 1'b1;
    for (int cyc = 0; cyc < 40 && col_out != 4'b1101; cyc++) @(negedge clk);
    repeat (6) @(negedge clk);
    check("debounce_col_frozen", col_out, 4'b1101);
    #2 reset = 1'b1;
    #1;
    check_reset("rst_in_debounce");
    pressed = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    #1;
    check("rst_debounce_no_pulse", kv_count - base, 0);

    // Reset in the wr_en cycle of a "1 2 D" commit.
    do_reset();
    press(pos_of(4'd1), 60);
    press(pos_of(4'd2), 60);
    base_wr = wr_count;
    pressed[15] = 1'b1;
    for (int cyc = 0; cyc < 100 && !key_valid; cyc++) @(negedge clk);
    check("wrst_key_d_accepted", {key_valid, key_code}, {1'b1, 4'd15});
    @(posedge clk);
    #1;
    check("wrst_wr_en_next_cycle", {wr_en, wr_data}, {1'b1, 6'd12});
    reset = 1'b1;
    #1;
    check_reset("rst_in_write");
    pressed = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    #1;
    check("wrst_no_write_seen", wr_count - base_wr, 0);

    // Random key sequences against the reference entry model.
    do_reset();
    m_tens = 4'd0;
    m_ones = 4'd0;
    m_addr = 1'b0;
    exp_err = 0;
    exp_q.delete();
    base_err = err_count;
    chk_en = 1'b1;
    for (int n = 0; n < 40; n++) begin
      r = int'($urandom_range(0, 9));
      if (r < 6) v = int'($urandom_range(0, 9));
      else if (r < 8) v = 13;
      else v = int'($urandom_range(10, 15));
      model_key(4'(v));
      press(pos_of(4'(v)), 60);
      #1;
      check($sformatf("rand%0d_entry_bcd", n), entry_bcd, {m_tens, m_ones});
      check($sformatf("rand%0d_entry_addr", n), entry_addr, m_addr);
    end
    check("rand_pending_writes", exp_q.size(), 0);
    check("rand_err_pulses", err_count - base_err, exp_err);
    chk_en = 1'b0;

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
